uart_disp_buffer: RTL and testbench

Upstream feeder for the 8-digit seven-segment scan driver in the UART communication/display design. Consumes the byte stream from the UART receiver and converts each ASCII character to an active-low segment pattern. Maintains an 8-digit shift buffer and presents it as the 64-bit display word plus the display-enable flag that the scan driver consumes. Also handles the editing commands dot, backspace and clear, and an optional idle blanking timer.

---
 rtl/uart_disp_buffer.sv | 161 ++++++++++++++++
 tb/tb_uart_disp_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_disp_buffer.sv
//==============================================================================
// uart_disp_buffer: turns a UART byte stream into an 8-digit active-low
// seven-segment buffer with dot/backspace/clear editing and idle blanking.
// Revision: 1.0
//==============================================================================
`default_nettype none

module uart_disp_buffer #(
    parameter int unsigned IDLE_BLANK_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [63:0] display,
    output logic        disp_en,
    output logic [3:0]  digit_cnt,
    output logic [7:0]  bad_cnt
);

    typedef enum logic [2:0] {
        CLS_GLYPH = 3'd0,
        CLS_DOT   = 3'd1,
        CLS_BKSP  = 3'd2,
        CLS_CLEAR = 3'd3,
        CLS_BAD   = 3'd4
    } cls_t;

    localparam logic [31:0] c_IDLE_LIMIT = 32'(IDLE_BLANK_CYCLES);
    localparam logic [63:0] c_BLANK      = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        r_rx_valid;
    logic [7:0]  r_rx_data;
    logic        r_s1_valid;
    cls_t        r_s1_cls;
    logic [7:0]  r_s1_code;
    logic [63:0] r_display;
    logic [3:0]  r_cnt;
    logic [7:0]  r_bad;
    logic        r_en;
    logic [31:0] r_idle;

    cls_t        w_cls;
    logic [7:0]  w_code;
    logic [63:0] w_nxt_display;
    logic [3:0]  w_nxt_cnt;
    logic        w_idle_hit;

    // Byte decode from the captured input byte
    always_comb begin
        w_cls  = CLS_GLYPH;
        w_code = 8'hFF;
        case (r_rx_data)
            8'h30: w_code = 8'h03;
            8'h31: w_code = 8'h9F;
            8'h32: w_code = 8'h25;
            8'h33: w_code = 8'h0D;
            8'h34: w_code = 8'h99;
            8'h35: w_code = 8'h49;
            8'h36: w_code = 8'h41;
            8'h37: w_code = 8'h1F;
            8'h38: w_code = 8'h01;
            8'h39: w_code = 8'h09;
            8'h41, 8'h61: w_code = 8'h11;
            8'h42, 8'h62: w_code = 8'hC1;
            8'h43, 8'h63: w_code = 8'h63;
            8'h44, 8'h64: w_code = 8'h85;
            8'h45, 8'h65: w_code = 8'h61;
            8'h46, 8'h66: w_code = 8'h71;
            8'h2D: w_code = 8'hFD;
            8'h20: w_code = 8'hFF;
            8'h2E: w_cls  = CLS_DOT;
            8'h08: w_cls  = CLS_BKSP;
            8'h0D, 8'h0A: w_cls = CLS_CLEAR;
            default: w_cls = CLS_BAD;
        endcase
    end

    // Buffer update for the stage-2 byte
    always_comb begin
        w_nxt_display = r_display;
        w_nxt_cnt     = r_cnt;
        case (r_s1_cls)
            CLS_GLYPH: begin
                w_nxt_display = {r_display[55:0], r_s1_code};
                w_nxt_cnt     = (r_cnt == 4'd8) ? 4'd8 : r_cnt + 4'd1;
            end
            CLS_DOT: begin
                if (r_cnt != 4'd0) begin
                    w_nxt_display = {r_display[63:1], 1'b0};
                end else begin
                    w_nxt_display = {r_display[55:0], 8'hFE};
                    w_nxt_cnt     = 4'd1;
                end
            end
            CLS_BKSP: begin
                if (r_cnt != 4'd0) begin
                    w_nxt_display = {8'hFF, r_display[63:8]};
                    w_nxt_cnt     = r_cnt - 4'd1;
                end
            end
            CLS_CLEAR: begin
                w_nxt_display = c_BLANK;
                w_nxt_cnt     = 4'd0;
            end
            default: begin
                w_nxt_display = r_display;
                w_nxt_cnt     = r_cnt;
            end
        endcase
    end

    assign w_idle_hit = (c_IDLE_LIMIT != 32'd0) && (r_idle == c_IDLE_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
            r_s1_valid <= 1'b0;
            r_s1_cls   <= CLS_BAD;
            r_s1_code  <= 8'hFF;
            r_display  <= c_BLANK;
            r_cnt      <= 4'd0;
            r_bad      <= 8'd0;
            r_en       <= 1'b0;
            r_idle     <= 32'd0;
        end else begin
            r_rx_valid <= rx_valid;
            r_rx_data  <= rx_data;
            r_s1_valid <= r_rx_valid;
            r_s1_cls   <= w_cls;
            r_s1_code  <= w_code;

            if (rx_valid) begin
                r_idle <= 32'd0;
            end else if ((c_IDLE_LIMIT != 32'd0) && (r_idle != c_IDLE_LIMIT)) begin
                r_idle <= r_idle + 32'd1;
            end

            // A buffer update takes priority over idle blanking
            if (r_s1_valid) begin
                r_display <= w_nxt_display;
                r_cnt     <= w_nxt_cnt;
                r_en      <= (w_nxt_cnt != 4'd0);
                if ((r_s1_cls == CLS_BAD) && (r_bad != 8'hFF)) begin
                    r_bad <= r_bad + 8'd1;
                end
            end else if (w_idle_hit) begin
                r_en <= 1'b0;
            end
        end
    end

    assign display   = r_display;
    assign disp_en   = r_en;
    assign digit_cnt = r_cnt;
    assign bad_cnt   = r_bad;

endmodule

`default_nettype wire

// File: tb/tb_uart_disp_buffer.sv
//==============================================================================
// tb_uart_disp_buffer: table-driven and directed checks of uart_disp_buffer.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_uart_disp_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [63:0] disp0, disp1;
    logic        en0, en1;
    logic [3:0]  cnt0, cnt1;
    logic [7:0]  bad0, bad1;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] c_BLANK = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    uart_disp_buffer #(.IDLE_BLANK_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .display(disp0), .disp_en(en0), .digit_cnt(cnt0), .bad_cnt(bad0)
    );

    uart_disp_buffer #(.IDLE_BLANK_CYCLES(20)) u_dut1 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .display(disp1), .disp_en(en1), .digit_cnt(cnt1), .bad_cnt(bad1)
    );

    typedef struct {
        logic [7:0]  b;
        logic [63:0] disp;
        logic [3:0]  cnt;
        logic        en;
        logic [7:0]  bad;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Single pulse; returns at the negedge just after the sampling edge
    task automatic pulse(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        pulse(b);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{8'h31, 64'hFFFF_FFFF_FFFF_FF9F, 4'd1, 1'b1, 8'd0};
        vecs[1]  = '{8'h32, 64'hFFFF_FFFF_FFFF_9F25, 4'd2, 1'b1, 8'd0};
        vecs[2]  = '{8'h2E, 64'hFFFF_FFFF_FFFF_9F24, 4'd2, 1'b1, 8'd0};
        vecs[3]  = '{8'h47, 64'hFFFF_FFFF_FFFF_9F24, 4'd2, 1'b1, 8'd1};
        vecs[4]  = '{8'h08, 64'hFFFF_FFFF_FFFF_FF9F, 4'd1, 1'b1, 8'd1};
        vecs[5]  = '{8'h08, c_BLANK,                 4'd0, 1'b0, 8'd1};
        vecs[6]  = '{8'h08, c_BLANK,                 4'd0, 1'b0, 8'd1};
        vecs[7]  = '{8'h2E, 64'hFFFF_FFFF_FFFF_FFFE, 4'd1, 1'b1, 8'd1};
        vecs[8]  = '{8'h61, 64'hFFFF_FFFF_FFFF_FE11, 4'd2, 1'b1, 8'd1};
        vecs[9]  = '{8'h46, 64'hFFFF_FFFF_FFFE_1171, 4'd3, 1'b1, 8'd1};
        vecs[10] = '{8'h2D, 64'hFFFF_FFFF_FE11_71FD, 4'd4, 1'b1, 8'd1};
        vecs[11] = '{8'h20, 64'hFFFF_FFFE_1171_FDFF, 4'd5, 1'b1, 8'd1};
        vecs[12] = '{8'h0A, c_BLANK,                 4'd0, 1'b0, 8'd1};
        vecs[13] = '{8'h63, 64'hFFFF_FFFF_FFFF_FF63, 4'd1, 1'b1, 8'd1};
        vecs[14] = '{8'h45, 64'hFFFF_FFFF_FFFF_6361, 4'd2, 1'b1, 8'd1};
        vecs[15] = '{8'h42, 64'hFFFF_FFFF_FF63_61C1, 4'd3, 1'b1, 8'd1};
        vecs[16] = '{8'h64, 64'hFFFF_FFFF_6361_C185, 4'd4, 1'b1, 8'd1};
        vecs[17] = '{8'h0D, c_BLANK,                 4'd0, 1'b0, 8'd1};

        // Reset state
        @(negedge clk);
        chk("rst_display", disp0, c_BLANK);
        chk("rst_en",      {63'd0, en0}, 64'd0);
        chk("rst_cnt",     {60'd0, cnt0}, 64'd0);
        chk("rst_bad",     {56'd0, bad0}, 64'd0);
        do_reset();

        // Table-driven single bytes
        for (int i = 0; i < 18; i++) begin
            send(vecs[i].b);
            chk($sformatf("vec%0d_display", i), disp0, vecs[i].disp);
            chk($sformatf("vec%0d_cnt", i), {60'd0, cnt0}, {60'd0, vecs[i].cnt});
            chk($sformatf("vec%0d_en", i), {63'd0, en0}, {63'd0, vecs[i].en});
            chk($sformatf("vec%0d_bad", i), {56'd0, bad0}, {56'd0, vecs[i].bad});
        end

        // Latency: unchanged after N+1, updated after N+2
        do_reset();
        pulse(8'h31);
        chk("lat_n0", disp0, c_BLANK);
        @(negedge clk);
        chk("lat_n1", disp0, c_BLANK);
        @(negedge clk);
        chk("lat_n2", disp0, 64'hFFFF_FFFF_FFFF_FF9F);
        send(8'h32);
        chk("t1_display", disp0, 64'hFFFF_FFFF_FFFF_9F25);
        chk("t1_en", {63'd0, en0}, 64'd1);

        // Back-to-back "0123456789"
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(8'h30 + i);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_display", disp0, 64'h250D_9949_411F_0109);
        chk("b2b_cnt", {60'd0, cnt0}, 64'd8);

        // Clear: disp_en drops on the same edge the display blanks
        do_reset();
        send(8'h35);
        send(8'h46);
        pulse(8'h0D);
        @(negedge clk);
        chk("clr_n1_display", disp0, 64'hFFFF_FFFF_FFFF_4971);
        chk("clr_n1_en", {63'd0, en0}, 64'd1);
        @(negedge clk);
        chk("clr_n2_display", disp0, c_BLANK);
        chk("clr_n2_en", {63'd0, en0}, 64'd0);
        chk("clr_n2_cnt", {60'd0, cnt0}, 64'd0);

        // Bad-byte saturation
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h47;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("bad_display", disp0, c_BLANK);
        chk("bad_sat", {56'd0, bad0}, 64'd255);
        send(8'h31);
        chk("bad_after_glyph", {56'd0, bad0}, 64'd255);
        chk("bad_glyph_display", disp0, 64'hFFFF_FFFF_FFFF_FF9F);

        // Idle blanking on the IDLE_BLANK_CYCLES=20 instance
        do_reset();
        pulse(8'h37);
        repeat (14) @(negedge clk);
        chk("idle_early_en", {63'd0, en1}, 64'd1);
        repeat (11) @(negedge clk);
        chk("idle_en", {63'd0, en1}, 64'd0);
        chk("idle_digit", {56'd0, disp1[7:0]}, 64'h1F);
        chk("idle_cnt", {60'd0, cnt1}, 64'd1);
        chk("idle_off_en", {63'd0, en0}, 64'd1);
        send(8'h38);
        chk("idle_reen", {63'd0, en1}, 64'd1);
        chk("idle_reen_display", {48'd0, disp1[15:0]}, 64'h1F01);

        // Mid-stream reset discards the in-flight byte
        pulse(8'h39);
        rst = 1'b1;
        #1;
        chk("mrst_display", disp0, c_BLANK);
        chk("mrst_cnt", {60'd0, cnt0}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("mrst_after_display", disp0, c_BLANK);
        chk("mrst_after_en", {63'd0, en0}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
